// File: rtl/jtag_scan_sequencer.sv
// JTAG master sequencer: turns TAP-reset / IR-scan / DR-scan / idle-run commands into
// registered TMS/TDI streams, captures TDO during shift states and mirrors the TAP state.
module jtag_scan_sequencer #(
  parameter int unsigned MAX_LEN = 32,
  parameter int unsigned LEN_W   = 6
) (
  input  logic               clk,
  input  logic               TRST,
  input  logic               cmd_valid,
  output logic               cmd_ready,
  input  logic [1:0]         cmd_type,
  input  logic [LEN_W-1:0]   cmd_len,
  input  logic [MAX_LEN-1:0] cmd_data,
  output logic               tms,
  output logic               tdi,
  input  logic               tdo,
  output logic               rsp_valid,
  output logic [MAX_LEN-1:0] rsp_data,
  output logic               busy,
  output logic [3:0]         state_obs
);

  localparam int unsigned IdxW = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
  localparam logic [LEN_W-1:0] MaxLenW = LEN_W'(MAX_LEN);
  localparam logic [LEN_W-1:0] OneW    = LEN_W'(1);

  localparam logic [1:0] CmdReset = 2'b00;
  localparam logic [1:0] CmdIr    = 2'b01;
  localparam logic [1:0] CmdDr    = 2'b10;
  localparam logic [1:0] CmdRun   = 2'b11;

  typedef enum logic [3:0] {
    TapTlr     = 4'h0, TapRti     = 4'h1, TapSelDr   = 4'h2, TapCapDr   = 4'h3,
    TapShiftDr = 4'h4, TapExit1Dr = 4'h5, TapPauseDr = 4'h6, TapExit2Dr = 4'h7,
    TapUpdDr   = 4'h8, TapSelIr   = 4'h9, TapCapIr   = 4'hA, TapShiftIr = 4'hB,
    TapExit1Ir = 4'hC, TapPauseIr = 4'hD, TapExit2Ir = 4'hE, TapUpdIr   = 4'hF
  } tap_e;

  typedef enum logic [2:0] {
    StBoot, StIdle, StNavPre, StShift, StNavPost, StRun, StResp
  } st_e;

  function automatic tap_e tap_next(input tap_e s, input logic t);
    tap_e n;
    case (s)
      TapTlr:     n = t ? TapTlr     : TapRti;
      TapRti:     n = t ? TapSelDr   : TapRti;
      TapSelDr:   n = t ? TapSelIr   : TapCapDr;
      TapCapDr:   n = t ? TapExit1Dr : TapShiftDr;
      TapShiftDr: n = t ? TapExit1Dr : TapShiftDr;
      TapExit1Dr: n = t ? TapUpdDr   : TapPauseDr;
      TapPauseDr: n = t ? TapExit2Dr : TapPauseDr;
      TapExit2Dr: n = t ? TapUpdDr   : TapShiftDr;
      TapUpdDr:   n = t ? TapSelDr   : TapRti;
      TapSelIr:   n = t ? TapTlr     : TapCapIr;
      TapCapIr:   n = t ? TapExit1Ir : TapShiftIr;
      TapShiftIr: n = t ? TapExit1Ir : TapShiftIr;
      TapExit1Ir: n = t ? TapUpdIr   : TapPauseIr;
      TapPauseIr: n = t ? TapExit2Ir : TapPauseIr;
      TapExit2Ir: n = t ? TapUpdIr   : TapShiftIr;
      TapUpdIr:   n = t ? TapSelDr   : TapRti;
      default:    n = TapTlr;
    endcase
    return n;
  endfunction

  st_e                st_q, st_d;
  tap_e               tap_q;
  logic [2:0]         step_q, step_d;
  logic [LEN_W-1:0]   cnt_q, cnt_d;
  logic [LEN_W-1:0]   n_q, n_d, n_eff;
  logic [1:0]         typ_q, typ_d;
  logic [MAX_LEN-1:0] data_q, data_d;
  logic [MAX_LEN-1:0] rsp_data_q;
  logic               tms_q, tms_d;
  logic               tdi_q, tdi_d;
  logic               accept;
  logic [2:0]         pre_last;

  assign cmd_ready = (st_q == StIdle) && (tap_q == TapRti) && (st_q != StResp);
  assign accept    = cmd_valid && cmd_ready;
  assign rsp_valid = (st_q == StResp);
  assign busy      = (st_q != StIdle);
  assign tms       = tms_q;
  assign tdi       = tdi_q;
  assign rsp_data  = rsp_data_q;
  assign state_obs = tap_q;

  always_comb begin
    n_eff = cmd_len;
    if (cmd_len == '0) begin
      n_eff = OneW;
    end else if (cmd_len > MaxLenW) begin
      n_eff = MaxLenW;
    end
  end

  // Last index of the navigation prefix; a TAP reset lives entirely in the prefix.
  always_comb begin
    case (typ_q)
      CmdIr:   pre_last = 3'd3;
      CmdDr:   pre_last = 3'd2;
      default: pre_last = 3'd5;
    endcase
  end

  always_comb begin
    typ_d  = accept ? cmd_type : typ_q;
    n_d    = accept ? n_eff    : n_q;
    data_d = accept ? cmd_data : data_q;
    st_d   = st_q;
    step_d = step_q;
    cnt_d  = cnt_q;

    case (st_q)
      StBoot: begin
        // One tms=1 cycle is already on the pins from reset; next comes one tms=0 cycle.
        if (!tms_q) st_d = StIdle;
      end
      StIdle: begin
        if (accept) begin
          if (cmd_type == CmdRun) begin
            st_d  = StRun;
            cnt_d = '0;
          end else begin
            st_d   = StNavPre;
            step_d = '0;
          end
        end
      end
      StNavPre: begin
        if (step_q == pre_last) begin
          if (typ_q == CmdReset) begin
            st_d = StResp;
          end else begin
            st_d  = StShift;
            cnt_d = '0;
          end
        end else begin
          step_d = step_q + 3'd1;
        end
      end
      StShift: begin
        if (cnt_q == n_q - OneW) begin
          st_d   = StNavPost;
          step_d = '0;
        end else begin
          cnt_d = cnt_q + OneW;
        end
      end
      StNavPost: begin
        if (step_q != '0) st_d = StResp;
        else              step_d = 3'd1;
      end
      StRun: begin
        if (cnt_q == n_q - OneW) st_d = StResp;
        else                     cnt_d = cnt_q + OneW;
      end
      StResp:  st_d = StIdle;
      default: st_d = StBoot;
    endcase
  end

  // TMS/TDI for the cycle that the next phase describes.
  always_comb begin
    tms_d = 1'b0;
    tdi_d = 1'b0;
    case (st_d)
      StNavPre: begin
        case (typ_d)
          CmdIr:    tms_d = (step_d < 3'd2);
          CmdDr:    tms_d = (step_d == 3'd0);
          CmdReset: tms_d = (step_d < 3'd5);
          default:  tms_d = 1'b0;
        endcase
      end
      StShift: begin
        tms_d = (cnt_d == n_d - OneW);
        tdi_d = data_d[cnt_d[IdxW-1:0]];
      end
      StNavPost: tms_d = (step_d == 3'd0);
      default:   tms_d = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (TRST) begin
      st_q       <= StBoot;
      tap_q      <= TapTlr;
      step_q     <= '0;
      cnt_q      <= '0;
      n_q        <= OneW;
      typ_q      <= CmdReset;
      data_q     <= '0;
      rsp_data_q <= '0;
      tms_q      <= 1'b1;
      tdi_q      <= 1'b0;
    end else begin
      st_q   <= st_d;
      tap_q  <= tap_next(tap_q, tms_q);
      step_q <= step_d;
      cnt_q  <= cnt_d;
      n_q    <= n_d;
      typ_q  <= typ_d;
      data_q <= data_d;
      tms_q  <= tms_d;
      tdi_q  <= tdi_d;
      if (accept) begin
        rsp_data_q <= '0;
      end else if (st_q == StShift) begin
        rsp_data_q[cnt_q[IdxW-1:0]] <= tdo;
      end
    end
  end

endmodule

// File: tb/tb_jtag_scan_sequencer.sv
// Scoreboard bench for jtag_scan_sequencer: directed commands push expected responses,
// a negedge monitor records each command's pin activity and checks it on rsp_valid.
module tb_jtag_scan_sequencer;

  localparam int MAX_LEN = 32;
  localparam int LEN_W   = 6;

  logic               clk = 1'b0;
  logic               TRST;
  logic               cmd_valid;
  logic               cmd_ready;
  logic [1:0]         cmd_type;
  logic [LEN_W-1:0]   cmd_len;
  logic [MAX_LEN-1:0] cmd_data;
  logic               tms;
  logic               tdi;
  logic               tdo;
  logic               rsp_valid;
  logic [MAX_LEN-1:0] rsp_data;
  logic               busy;
  logic [3:0]         state_obs;
  logic               loop_en;
  logic               tdo_const;

  always #5 clk = ~clk;
  assign tdo = loop_en ? tdi : tdo_const;

  jtag_scan_sequencer #(.MAX_LEN(MAX_LEN), .LEN_W(LEN_W)) dut (
    .clk       (clk),
    .TRST      (TRST),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_type  (cmd_type),
    .cmd_len   (cmd_len),
    .cmd_data  (cmd_data),
    .tms       (tms),
    .tdi       (tdi),
    .tdo       (tdo),
    .rsp_valid (rsp_valid),
    .rsp_data  (rsp_data),
    .busy      (busy),
    .state_obs (state_obs)
  );

  typedef struct {
    logic [31:0] data;
    int          cycles;
    logic [63:0] tms_seq;
    logic [31:0] tdi_seq;
    int          shifts;
    bit          chk_st;
    logic [63:0] states;
  } exp_t;

  exp_t sbq[$];
  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int acc_cyc = 0;
  int last_rsp_cyc = -1;
  int nrsp = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0h, required %0h", name, act, req);
    end
  endtask

  task automatic push(input logic [31:0] d, input int cycles, input logic [63:0] tseq,
                      input logic [31:0] iseq, input int shifts, input bit chk,
                      input logic [63:0] st);
    exp_t e;
    e.data = d; e.cycles = cycles; e.tms_seq = tseq; e.tdi_seq = iseq;
    e.shifts = shifts; e.chk_st = chk; e.states = st;
    sbq.push_back(e);
  endtask

  // Monitor: record every cycle from acceptance to rsp_valid, then score it.
  bit          rec = 0;
  int          k;
  int          shf;
  logic [63:0] tms_acc;
  logic [31:0] tdi_acc;
  logic [63:0] st_acc;

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (TRST) begin
        rec = 0;
      end else if (rec) begin
        if (rsp_valid) begin
          rec = 0;
          nrsp++;
          last_rsp_cyc = cyc;
          if (sbq.size() == 0) begin
            total++; bad++;
            $display("FAIL unexpected_rsp: got rsp_valid data %0h, required no response", rsp_data);
          end else begin
            e = sbq.pop_front();
            check("rsp_data",    64'(rsp_data),  64'(e.data));
            check("seq_cycles",  64'(k),         64'(e.cycles));
            check("tms_seq",     tms_acc,        e.tms_seq);
            check("tdi_shift",   64'(tdi_acc),   64'(e.tdi_seq));
            check("shift_count", 64'(shf),       64'(e.shifts));
            check("rsp_state",   64'(state_obs), 64'(1));
            if (e.chk_st) check("state_trace", st_acc, e.states);
          end
        end else begin
          if (k < 64) tms_acc[k] = tms;
          if (k < 16) st_acc[k*4 +: 4] = state_obs;
          if (state_obs == 4'b0100 || state_obs == 4'b1011) begin
            if (shf < 32) tdi_acc[shf] = tdi;
            shf++;
          end else begin
            check("tdi_idle", 64'(tdi), 64'(0));
          end
          k++;
          if (k > 300) begin
            total++; bad++;
            $display("FAIL rsp_timeout: got no rsp_valid after %0d cycles, required one", k);
            rec = 0;
          end
        end
      end
      if (!TRST && cmd_valid && cmd_ready) begin
        rec = 1; k = 0; shf = 0; tms_acc = '0; tdi_acc = '0; st_acc = '0;
      end
    end
  end

  task automatic issue(input logic [1:0] t, input logic [LEN_W-1:0] len,
                       input logic [31:0] d, input bit hold);
    cmd_type = t; cmd_len = len; cmd_data = d; cmd_valid = 1'b1;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (cmd_ready) break;
    end
    if (!cmd_ready) begin
      total++; bad++;
      $display("FAIL accept_timeout: got cmd_ready=0, required 1");
    end
    acc_cyc = cyc;
    @(posedge clk); #1;
    if (!hold) cmd_valid = 1'b0;
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 400; i++) begin
      if (sbq.size() == 0 && !busy) break;
      @(posedge clk); #1;
    end
    if (sbq.size() != 0 || busy) begin
      total++; bad++;
      $display("FAIL idle_timeout: got busy=%0d pending=%0d, required idle", busy, sbq.size());
    end
  endtask

  // Called just after a reset edge has been sampled; releases TRST and checks the boot.
  task automatic release_and_check();
    @(posedge clk); #1;
    TRST = 1'b0;
    @(negedge clk);
    check("rel_tms_hi",  64'(tms), 64'(1));
    @(negedge clk);
    check("boot_tms",    64'(tms), 64'(0));
    check("boot_state",  64'(state_obs), 64'(0));
    check("boot_busy",   64'(busy), 64'(1));
    check("boot_ready",  64'(cmd_ready), 64'(0));
    @(negedge clk);
    check("idle_state",  64'(state_obs), 64'(1));
    check("idle_ready",  64'(cmd_ready), 64'(1));
    check("idle_busy",   64'(busy), 64'(0));
    @(posedge clk); #1;
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, "_tms"},      64'(tms), 64'(1));
    check({tag, "_tdi"},      64'(tdi), 64'(0));
    check({tag, "_ready"},    64'(cmd_ready), 64'(0));
    check({tag, "_rspv"},     64'(rsp_valid), 64'(0));
    check({tag, "_rsp_data"}, 64'(rsp_data), 64'(0));
    check({tag, "_busy"},     64'(busy), 64'(1));
    check({tag, "_state"},    64'(state_obs), 64'(0));
  endtask

  initial begin : stim
    int saved;
    TRST = 1'b1; cmd_valid = 1'b0; cmd_type = '0; cmd_len = '0; cmd_data = '0;
    loop_en = 1'b0; tdo_const = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_reset_state("reset");
    release_and_check();

    // IR scan N=4, data 1010, tdo held high
    tdo_const = 1'b1;
    push(32'h0000_000F, 10, 64'h183, 32'hA, 4, 1, 64'h0000_00FC_BBBB_A921);
    issue(2'b01, 6'd4, 32'hA, 0);
    wait_idle();

    // Idle run N=3 must also clear the previous rsp_data
    push(32'h0, 3, 64'h0, 32'h0, 0, 1, 64'h111);
    issue(2'b11, 6'd3, 32'hFFFF, 0);
    wait_idle();

    // DR loopback N=8, data A5
    loop_en = 1'b1;
    push(32'hA5, 13, 64'hC01, 32'hA5, 8, 1, 64'h0008_5444_4444_4321);
    issue(2'b10, 6'd8, 32'hA5, 0);
    wait_idle();

    // TAP reset
    push(32'h0, 6, 64'h1F, 32'h0, 0, 1, 64'h921);
    issue(2'b00, 6'd0, 32'hFFFF_FFFF, 0);
    wait_idle();

    // Idle run with cmd_len=0 behaves as one cycle
    push(32'h0, 1, 64'h0, 32'h0, 0, 1, 64'h1);
    issue(2'b11, 6'd0, 32'h0, 0);
    wait_idle();

    // Back-to-back IR then DR with cmd_valid held high
    loop_en = 1'b0; tdo_const = 1'b1;
    push(32'h7, 9, 64'hC3, 32'h6, 3, 0, 64'h0);
    push(32'h3, 7, 64'h31, 32'h1, 2, 0, 64'h0);
    issue(2'b01, 6'd3, 32'h6, 1);
    issue(2'b10, 6'd2, 32'h1, 0);
    check("b2b_accept", 64'(acc_cyc), 64'(last_rsp_cyc + 1));
    wait_idle();

    // cmd_len=0 DR scan: single shift with tms=1, bit0 from tdo
    push(32'h1, 6, 64'h19, 32'h0, 1, 1, 64'h85_4321);
    issue(2'b10, 6'd0, 32'hFFFF_FFFE, 0);
    wait_idle();

    // cmd_len=40 clamps to 32 shifts
    loop_en = 1'b1;
    push(32'h1234_5678, 37, 64'h0000_000C_0000_0001, 32'h1234_5678, 32, 0, 64'h0);
    issue(2'b10, 6'd40, 32'h1234_5678, 0);
    wait_idle();

    // Reset during shift bit 3 of a 16-bit DR scan: no response allowed
    saved = nrsp;
    issue(2'b10, 6'd16, 32'hBEEF, 0);
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (state_obs == 4'b0100) break;
    end
    check("abort_reached_shift", 64'(state_obs), 64'(4'b0100));
    repeat (3) @(posedge clk);
    #1 TRST = 1'b1;
    @(negedge clk);
    @(negedge clk);
    check_reset_state("abort");
    release_and_check();
    repeat (5) @(posedge clk);
    check("abort_no_rsp", 64'(nrsp), 64'(saved));
    check("sb_drained",   64'(sbq.size()), 64'(0));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
